// File: rtl/or3_pkg.sv
// Shared defaults and helpers for the three-input OR unit.
// Provides the default widths and a width-agnostic saturating increment.
package or3_pkg;

  localparam int unsigned OR3_WIDTH  = 1;
  localparam int unsigned OR3_CNT_W  = 16;
  localparam int unsigned OR3_MAX_CW = 64;

  // All-ones value for a counter of width w (w clipped to 64 bits).
  function automatic logic [OR3_MAX_CW-1:0] cnt_max(input int unsigned w);
    logic [OR3_MAX_CW-1:0] r_max;
    if (w >= OR3_MAX_CW) begin
      r_max = '1;
    end else begin
      r_max = (64'd1 << w) - 64'd1;
    end
    return r_max;
  endfunction

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [OR3_MAX_CW-1:0] sat_inc(
    input logic [OR3_MAX_CW-1:0] val,
    input logic [OR3_MAX_CW-1:0] max_val
  );
    logic [OR3_MAX_CW-1:0] r_next;
    if (val >= max_val) begin
      r_next = max_val;
    end else begin
      r_next = val + 64'd1;
    end
    return r_next;
  endfunction

endpackage

// File: rtl/or3_cell.sv
// One-bit combinational three-input OR leaf.
module or3_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_y_c
);

  assign o_y_c = i_a | i_b | i_c;

endmodule

// File: rtl/or3_gate_unit.sv
// Bitwise three-input OR with registered copy, saturating hit counter and optional sticky bits.
// Optional feature macro: OR3_STICKY_EN (per-bit accumulated y with clear).
module or3_gate_unit
  import or3_pkg::*;
#(
  parameter int unsigned WIDTH = OR3_WIDTH,
  parameter int unsigned CNT_W = OR3_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             y_any,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [WIDTH-1:0] sticky,
  input  logic             sticky_clr
);

  localparam logic [OR3_MAX_CW-1:0] CNT_MAX = cnt_max(CNT_W);

  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] r_y_q;
  logic [CNT_W-1:0] r_hit_cnt;

  // One OR leaf per bit; y and y_any stay live through reset.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    or3_cell u_cell (
      .i_a   (a[gi]),
      .i_b   (b[gi]),
      .i_c   (c[gi]),
      .o_y_c (w_y[gi])
    );
  end

  assign y     = w_y;
  assign y_any = |w_y;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y_q <= '0;
    end else begin
      r_y_q <= w_y;
    end
  end

  // Counts sampled cycles with any output bit high; parks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hit_cnt <= '0;
    end else if (y_any) begin
      r_hit_cnt <= CNT_W'(sat_inc(OR3_MAX_CW'(r_hit_cnt), CNT_MAX));
    end
  end

  assign y_q     = r_y_q;
  assign hit_cnt = r_hit_cnt;

`ifdef OR3_STICKY_EN
  logic [WIDTH-1:0] r_sticky;

  // Clear has priority over capturing new bits in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sticky <= '0;
    end else if (sticky_clr) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= r_sticky | w_y;
    end
  end

  assign sticky = r_sticky;
`else
  logic w_unused_sticky_clr;

  assign w_unused_sticky_clr = sticky_clr;
  assign sticky              = '0;
`endif

endmodule

// File: tb/tb_or3_gate_unit.sv
// Scoreboard bench for or3_gate_unit: stimulus queues expectations, a monitor compares.
module tb_or3_gate_unit;

  localparam int SIG_Y1    = 0;
  localparam int SIG_YANY1 = 1;
  localparam int SIG_YQ1   = 2;
  localparam int SIG_HIT1  = 3;
  localparam int SIG_HITS  = 4;
  localparam int SIG_Y4    = 5;
  localparam int SIG_YANY4 = 6;
  localparam int SIG_YQ4   = 7;
  localparam int SIG_HIT4  = 8;
  localparam int SIG_ST4   = 9;

`ifdef OR3_STICKY_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  logic clk;
  logic clk_run;
  logic rst_n;

  logic        a1, b1, c1, clr1;
  logic        y1, yq1, yany1, st1;
  logic [15:0] hit1;

  logic        as, bs, cs, clrs;
  logic        ys, yqs, yanys, sts;
  logic [1:0]  hits;

  logic [3:0]  a4, b4, c4, y4, yq4, st4;
  logic        yany4, clr4;
  logic [15:0] hit4;

  or3_gate_unit #(.WIDTH(1), .CNT_W(16)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1), .y(y1), .y_q(yq1),
    .y_any(yany1), .hit_cnt(hit1), .sticky(st1), .sticky_clr(clr1)
  );

  or3_gate_unit #(.WIDTH(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .a(as), .b(bs), .c(cs), .y(ys), .y_q(yqs),
    .y_any(yanys), .hit_cnt(hits), .sticky(sts), .sticky_clr(clrs)
  );

  or3_gate_unit #(.WIDTH(4), .CNT_W(16)) u_w4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .c(c4), .y(y4), .y_q(yq4),
    .y_any(yany4), .hit_cnt(hit4), .sticky(st4), .sticky_clr(clr4)
  );

  typedef struct {
    string       name;
    int          sig;
    logic [15:0] exp;
  } chk_t;

  chk_t q[$];
  int   errors;
  int   checks;
  event ev_chk;

  initial begin
    clk = 1'b0;
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  task automatic expect_val(input string n, input int sig, input logic [15:0] e);
    chk_t t;
    t.name = n;
    t.sig  = sig;
    t.exp  = e;
    q.push_back(t);
  endtask

  function automatic logic [15:0] sample(input int sig);
    logic [15:0] v;
    v = '0;
    case (sig)
      SIG_Y1:    v[0]   = y1;
      SIG_YANY1: v[0]   = yany1;
      SIG_YQ1:   v[0]   = yq1;
      SIG_HIT1:  v      = hit1;
      SIG_HITS:  v[1:0] = hits;
      SIG_Y4:    v[3:0] = y4;
      SIG_YANY4: v[0]   = yany4;
      SIG_YQ4:   v[3:0] = yq4;
      SIG_HIT4:  v      = hit4;
      SIG_ST4:   v[3:0] = st4;
      default:   v      = 16'hdead;
    endcase
    return v;
  endfunction

  // Monitor: drains the scoreboard each time the stimulus signals a sample point.
  initial begin
    chk_t        t;
    logic [15:0] act;
    forever begin
      @(ev_chk);
      while (q.size() > 0) begin
        t   = q.pop_front();
        act = sample(t.sig);
        checks++;
        if (act !== t.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h at %0t", t.name, act, t.exp, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  vec   [8];
    logic        exp_y [8];
    logic        exp_yq1  [6];
    logic [15:0] exp_hit1 [6];
    logic [1:0]  exp_hits [6];
    logic [3:0]  st_a  [5];
    logic [3:0]  st_b  [5];
    logic [3:0]  st_c  [5];
    logic        st_clr[5];
    logic [3:0]  st_exp[5];
    logic [15:0] st_hit[5];

    vec      = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111};
    exp_y    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_yq1  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_hit1 = '{16'd1, 16'd2, 16'd3, 16'd3, 16'd3, 16'd3};
    exp_hits = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    st_a     = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    st_b     = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    st_c     = '{4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b1000};
    st_clr   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    st_exp   = '{4'b0001, 4'b0101, 4'b0000, 4'b0000, 4'b1000};
    st_hit   = '{16'd1, 16'd2, 16'd3, 16'd3, 16'd4};

    errors = 0; checks = 0; clk_run = 1'b0; rst_n = 1'b0;
    a1 = 0; b1 = 0; c1 = 0; clr1 = 0;
    as = 0; bs = 0; cs = 0; clrs = 0;
    a4 = '0; b4 = '0; c4 = '0; clr4 = 0;

    // Exhaustive truth table with the clock stopped.
    for (int i = 0; i < 8; i++) begin
      {a1, b1, c1} = vec[i];
      #1;
      expect_val($sformatf("tt_y_%0d", i), SIG_Y1, {15'b0, exp_y[i]});
      expect_val($sformatf("tt_any_%0d", i), SIG_YANY1, {15'b0, exp_y[i]});
      -> ev_chk;
      #9;
    end

    a1 = 1'bx; b1 = 1'b1; c1 = 1'b0; #1;
    expect_val("x_dominated_by_1", SIG_Y1, 16'd1);
    -> ev_chk; #9;
    a1 = 1'bx; b1 = 1'b0; c1 = 1'b0; #1;
    expect_val("x_propagates", SIG_Y1, {15'b0, 1'bx});
    -> ev_chk; #9;

    a4 = 4'b0001; b4 = 4'b0100; c4 = 4'b0000; #1;
    expect_val("w4_y", SIG_Y4, 16'h0005);
    expect_val("w4_any", SIG_YANY4, 16'd1);
    -> ev_chk; #9;

    // Held in reset: y tracks inputs, registers stay cleared.
    clk_run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a1 = i[0]; b1 = 0; c1 = 0; as = 1; a4 = 4'b1111;
      #1;
      expect_val($sformatf("rst_y_%0d", i), SIG_Y1, {15'b0, i[0]});
      -> ev_chk;
      @(posedge clk); #1;
      expect_val($sformatf("rst_yq_%0d", i), SIG_YQ1, 16'd0);
      expect_val($sformatf("rst_hit_%0d", i), SIG_HIT1, 16'd0);
      expect_val($sformatf("rst_hits_%0d", i), SIG_HITS, 16'd0);
      expect_val($sformatf("rst_hit4_%0d", i), SIG_HIT4, 16'd0);
      -> ev_chk;
    end

    // Run: w1 hit for three cycles, saturating counter hit for six.
    @(negedge clk);
    rst_n = 1'b1; a4 = '0; b4 = '0; c4 = '0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      a1 = (i < 3); as = 1'b1;
      if (i == 0) begin
        #1;
        expect_val("lag_y", SIG_Y1, 16'd1);
        expect_val("lag_yq", SIG_YQ1, 16'd0);
        -> ev_chk;
      end
      @(posedge clk); #1;
      expect_val($sformatf("run_yq_%0d", i), SIG_YQ1, {15'b0, exp_yq1[i]});
      expect_val($sformatf("run_hit_%0d", i), SIG_HIT1, exp_hit1[i]);
      expect_val($sformatf("sat_hit_%0d", i), SIG_HITS, {14'b0, exp_hits[i]});
      -> ev_chk;
    end

    // Mid-operation reset discards history.
    @(negedge clk);
    rst_n = 1'b0; a1 = 1'b1;
    @(posedge clk); #1;
    expect_val("mid_rst_hit", SIG_HIT1, 16'd0);
    expect_val("mid_rst_yq", SIG_YQ1, 16'd0);
    expect_val("mid_rst_hits", SIG_HITS, 16'd0);
    expect_val("mid_rst_y", SIG_Y1, 16'd1);
    -> ev_chk;
    @(negedge clk);
    rst_n = 1'b1; a1 = 1'b0; as = 1'b0;
    @(posedge clk); #1;
    expect_val("post_rst_hit", SIG_HIT1, 16'd0);
    expect_val("post_rst_yq", SIG_YQ1, 16'd0);
    -> ev_chk;

    // Sticky accumulate and clear-wins on the 4-bit instance.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a4 = st_a[i]; b4 = st_b[i]; c4 = st_c[i]; clr4 = st_clr[i];
      @(posedge clk); #1;
      expect_val($sformatf("sticky_%0d", i), SIG_ST4, {12'b0, STICKY_ON ? st_exp[i] : 4'b0000});
      expect_val($sformatf("w4_yq_%0d", i), SIG_YQ4, {12'b0, st_a[i] | st_b[i] | st_c[i]});
      expect_val($sformatf("w4_hit_%0d", i), SIG_HIT4, st_hit[i]);
      -> ev_chk;
    end

    #20;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
